// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller driving a unipolar stepper
// through an 8-phase coil table, one floor per move leg.
module elevator_scan_ctrl #(
    parameter int FLOORS          = 4,
    parameter int STEPS_PER_FLOOR = 11719,
    parameter int STEP_DIV        = 75000,
    parameter int DWELL_CYC       = 200000000,
    parameter int HALF_STEP       = 1,
    parameter int FW              = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [FLOORS-1:0] call_pe,
    output logic [3:0]        motorpin,
    output logic [FW-1:0]     cur_floor,
    output logic [FLOORS-1:0] pending,
    output logic              moving,
    output logic              dir,
    output logic              door_open
);

    localparam int DIV_W   = $clog2(STEP_DIV);
    localparam int STEP_W  = $clog2(STEPS_PER_FLOOR + 1);
    localparam int DWELL_W = $clog2(DWELL_CYC + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEPS_PER_FLOOR - 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYC - 1);
    localparam logic [2:0]         PH_INC     = (HALF_STEP != 0) ? 3'd1 : 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DWELL
    } state_t;

    state_t              state_q, state_d;
    logic [FW-1:0]       floor_q, floor_d;
    logic [FLOORS-1:0]   pend_q, pend_d;
    logic                dir_q, dir_d;
    logic [2:0]          phase_q, phase_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [3:0]          motor_q, motor_d;

    logic [FLOORS-1:0]   clr_mask;
    logic [FW-1:0]       nxt_floor;

    // Any pending call strictly beyond floor fl in direction d.
    function automatic logic ahead(
        input logic [FLOORS-1:0] p,
        input logic [FW-1:0]     fl,
        input logic              d
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (d ? (i < int'(fl)) : (i > int'(fl)))) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Coil pattern {A,B,C,D} for a phase index.
    function automatic logic [3:0] coil_pat(input logic [2:0] p);
        logic [3:0] pat;
        case (p)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    // Next-state: SCAN decisions, step timing, dwell and call latching.
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        phase_d   = phase_q;
        div_d     = div_q;
        step_d    = step_q;
        dwell_d   = dwell_q;
        clr_mask  = '0;
        nxt_floor = dir_q ? (floor_q - FW'(1)) : (floor_q + FW'(1));

        unique case (state_q)
            S_IDLE: begin
                if (pend_q[floor_q]) begin
                    clr_mask[floor_q] = 1'b1;
                    dwell_d           = DWELL_LOAD;
                    state_d           = S_DWELL;
                end else if (|pend_q) begin
                    dir_d   = ahead(pend_q, floor_q, dir_q) ? dir_q : ~dir_q;
                    div_d   = '0;
                    step_d  = '0;
                    state_d = S_MOVE;
                    if (HALF_STEP == 0) begin
                        phase_d = phase_q | 3'd1;
                    end
                end
            end
            S_MOVE: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    phase_d = dir_q ? (phase_q - PH_INC) : (phase_q + PH_INC);
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        floor_d = nxt_floor;
                        if (pend_q[nxt_floor]) begin
                            clr_mask[nxt_floor] = 1'b1;
                            dwell_d             = DWELL_LOAD;
                            state_d             = S_DWELL;
                        end else if (!ahead(pend_q, nxt_floor, dir_q)) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DWELL: begin
                if (call_pe[floor_q]) begin
                    clr_mask[floor_q] = 1'b1;
                    dwell_d           = DWELL_LOAD;
                end else if (dwell_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pend_d  = (pend_q | call_pe) & ~clr_mask;
        motor_d = (state_d == S_MOVE) ? coil_pat(phase_d) : 4'b0000;
    end

    // State and datapath registers; reset abandons any move in progress.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= S_IDLE;
            floor_q <= '0;
            pend_q  <= '0;
            dir_q   <= 1'b0;
            phase_q <= 3'd0;
            div_q   <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            motor_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            motor_q <= motor_d;
        end
    end

    assign motorpin  = motor_q;
    assign cur_floor = floor_q;
    assign pending   = pend_q;
    assign moving    = (state_q == S_MOVE);
    assign dir       = dir_q;
    assign door_open = (state_q == S_DWELL);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Random and directed bench for elevator_scan_ctrl against
// a floor/timer level reference model.
module tb_elevator_scan_ctrl;

    localparam int FLOORS = 4;
    localparam int SPF    = 4;
    localparam int SDIV   = 3;
    localparam int DWELL  = 5;
    localparam int MD_IDLE  = 0;
    localparam int MD_MOVE  = 1;
    localparam int MD_DWELL = 2;

    logic       clk = 1'b0;
    logic       reset_p;
    logic [3:0] call_pe;

    logic [3:0] mp_h, mp_f;
    logic [1:0] fl_h, fl_f;
    logic [3:0] pend_h, pend_f;
    logic       mov_h, mov_f, dir_h, dir_f, door_h, door_f;

    int n_chk = 0;
    int n_err = 0;

    elevator_scan_ctrl #(
        .FLOORS(FLOORS), .STEPS_PER_FLOOR(SPF), .STEP_DIV(SDIV),
        .DWELL_CYC(DWELL), .HALF_STEP(1)
    ) u_half (
        .clk(clk), .reset_p(reset_p), .call_pe(call_pe),
        .motorpin(mp_h), .cur_floor(fl_h), .pending(pend_h),
        .moving(mov_h), .dir(dir_h), .door_open(door_h)
    );

    elevator_scan_ctrl #(
        .FLOORS(FLOORS), .STEPS_PER_FLOOR(SPF), .STEP_DIV(SDIV),
        .DWELL_CYC(DWELL), .HALF_STEP(0)
    ) u_full (
        .clk(clk), .reset_p(reset_p), .call_pe(call_pe),
        .motorpin(mp_f), .cur_floor(fl_f), .pending(pend_f),
        .moving(mov_f), .dir(dir_f), .door_open(door_f)
    );

    always #5 clk = ~clk;

    // reference model: car position, elapsed travel time, door timer
    int         m_mode, m_floor, m_elapsed, m_left, m_ph_h, m_ph_f;
    bit         m_dir;
    logic [3:0] m_pend;
    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    logic [1:0] stops[$];
    int         exp_stops [9] = '{0, 3, 2, 0, 1, 3, 1, 3, 0};
    bit         door_prev;
    int         door_cyc, mov_cyc, fs_bad;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit calls_ahead(int fl, bit d, logic [3:0] p);
        int pv;
        pv = int'(p);
        if (d) return (pv & ((1 << fl) - 1)) != 0;
        return (pv >> (fl + 1)) != 0;
    endfunction

    function automatic void model_reset();
        m_mode = MD_IDLE; m_floor = 0; m_elapsed = 0; m_left = 0;
        m_ph_h = 0; m_ph_f = 0; m_dir = 1'b0; m_pend = 4'b0000;
    endfunction

    function automatic void model_edge(logic [3:0] c);
        logic [3:0] clr;
        clr = 4'b0000;
        case (m_mode)
            MD_IDLE: begin
                if (m_pend[m_floor]) begin
                    clr[m_floor] = 1'b1;
                    m_left = DWELL;
                    m_mode = MD_DWELL;
                end else if (m_pend != 0) begin
                    if (!calls_ahead(m_floor, m_dir, m_pend)) m_dir = !m_dir;
                    m_elapsed = 0;
                    m_ph_f = m_ph_f | 1;
                    m_mode = MD_MOVE;
                end
            end
            MD_MOVE: begin
                m_elapsed++;
                if (m_elapsed % SDIV == 0) begin
                    m_ph_h = (m_ph_h + (m_dir ? 7 : 1)) % 8;
                    m_ph_f = (m_ph_f + (m_dir ? 6 : 2)) % 8;
                end
                if (m_elapsed == SPF * SDIV) begin
                    m_floor = m_floor + (m_dir ? -1 : 1);
                    m_elapsed = 0;
                    if (m_pend[m_floor]) begin
                        clr[m_floor] = 1'b1;
                        m_left = DWELL;
                        m_mode = MD_DWELL;
                    end else if (!calls_ahead(m_floor, m_dir, m_pend)) begin
                        m_mode = MD_IDLE;
                    end
                end
            end
            default: begin
                if (c[m_floor]) begin
                    clr[m_floor] = 1'b1;
                    m_left = DWELL;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = MD_IDLE;
                end
            end
        endcase
        m_pend = (m_pend | c) & ~clr;
    endfunction

    task automatic compare_all();
        logic [3:0] eh, ef;
        eh = (m_mode == MD_MOVE) ? tbl[m_ph_h] : 4'b0000;
        ef = (m_mode == MD_MOVE) ? tbl[m_ph_f] : 4'b0000;
        chk("motor_half", int'(mp_h), int'(eh));
        chk("motor_full", int'(mp_f), int'(ef));
        chk("cur_floor", int'(fl_h), m_floor);
        chk("pending", int'(pend_h), int'(m_pend));
        chk("moving", int'(mov_h), int'(m_mode == MD_MOVE));
        chk("dir", int'(dir_h), int'(m_dir));
        chk("door_open", int'(door_h), int'(m_mode == MD_DWELL));
        chk("full_floor", int'(fl_f), m_floor);
        chk("full_moving", int'(mov_f), int'(m_mode == MD_MOVE));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_motor_h"}, int'(mp_h), 0);
        chk({tag, "_motor_f"}, int'(mp_f), 0);
        chk({tag, "_floor"}, int'(fl_h), 0);
        chk({tag, "_pending"}, int'(pend_h), 0);
        chk({tag, "_moving"}, int'(mov_h | mov_f), 0);
        chk({tag, "_dir"}, int'(dir_h), 0);
        chk({tag, "_door"}, int'(door_h | door_f), 0);
    endtask

    task automatic tick(input logic [3:0] c);
        call_pe = c;
        @(posedge clk);
        model_edge(c);
        @(negedge clk);
        call_pe = 4'b0000;
        compare_all();
        if (door_h && !door_prev) stops.push_back(fl_h);
        door_prev = door_h;
        if (door_h) door_cyc++;
        if (mov_h) mov_cyc++;
        if (mov_f && !(mp_f inside {4'b1100, 4'b0110, 4'b0011, 4'b1001}))
            fs_bad++;
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while ((mov_h || door_h || pend_h != 0) && n < 400) begin
            tick(4'b0000);
            n++;
        end
        if (n >= 400) chk("idle_timeout", n, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(4'b0000);
    endtask

    initial begin
        int f;
        logic [3:0] c;
        reset_p = 1'b1;
        call_pe = 4'b0000;
        door_prev = 1'b0;
        door_cyc = 0; mov_cyc = 0; fs_bad = 0;
        model_reset();
        #3;
        chk_reset("por");
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        compare_all();

        // call at the current floor: door only, no travel
        door_cyc = 0; mov_cyc = 0;
        tick(4'b0001);
        run_until_idle();
        ticks(2);
        chk("s1_door_cycles", door_cyc, DWELL);
        chk("s1_no_move", mov_cyc, 0);

        // full trip 0 -> 3, latency and floor time
        mov_cyc = 0;
        tick(4'b1000);
        chk("s2_pend_latched", int'(pend_h), 8);
        chk("s2_not_yet_moving", int'(mov_h), 0);
        tick(4'b0000);
        chk("s2_moving_up", int'(mov_h), 1);
        chk("s2_dir_up", int'(dir_h), 0);
        run_until_idle();
        chk("s2_travel_cycles", mov_cyc, 3 * SPF * SDIV);
        chk("s2_floor3", int'(fl_h), 3);

        // down with an intermediate call for 2
        tick(4'b0001);
        ticks(5);
        chk("s3_dir_down", int'(dir_h), 1);
        tick(4'b0100);
        run_until_idle();

        // up with an intermediate call for 1
        tick(4'b1000);
        ticks(5);
        tick(4'b0010);
        run_until_idle();

        // 3 -> 1, then 1 -> 3 with a call behind at 0
        tick(4'b0010);
        run_until_idle();
        tick(4'b1000);
        ticks(5);
        tick(4'b0001);
        chk("s5_behind_pending", int'(pend_h[0]), 1);
        run_until_idle();

        chk("stop_count", stops.size(), 9);
        for (int i = 0; i < 9 && i < stops.size(); i++)
            chk("stop_order", int'(stops[i]), exp_stops[i]);

        // random call traffic
        for (int i = 0; i < 2500; i++) begin
            c = 4'b0000;
            if ($urandom_range(0, 11) == 0) c[$urandom_range(0, 3)] = 1'b1;
            if ($urandom_range(0, 63) == 0) c = 4'($urandom_range(0, 15));
            tick(c);
        end
        run_until_idle();
        chk("fs_odd_only", fs_bad, 0);

        // reset in the middle of a move
        f = (m_floor == 0) ? 3 : 0;
        c = 4'b0000;
        c[f] = 1'b1;
        tick(c);
        ticks(7);
        chk("pre_reset_moving", int'(mov_h), 1);
        #2;
        reset_p = 1'b1;
        #1;
        chk_reset("async");
        model_reset();
        door_prev = 1'b0;
        @(negedge clk);
        chk_reset("held");
        reset_p = 1'b0;
        ticks(3);
        tick(4'b0100);
        run_until_idle();
        chk("post_reset_floor", int'(fl_h), 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
